// File: rtl/ser_pkg.sv
// Shared types and helpers for the bit serializer (optional parity: BIT_SERIALIZER_PARITY_EN).
// Pure declarations, no latency or backpressure.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/ser_gap_counter.sv
// Loadable down-counter; done_o flags the last counted cycle (count == 1).
// One-cycle load latency, no backpressure.
module ser_gap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder; first bit one cycle after handshake, optional even parity (BIT_SERIALIZER_PARITY_EN).
// in_ready drops while a frame or gap is running, except on the final bit when GAP_CYCLES == 0.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             frame_done
);

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL = frame_len(WIDTH, PAR_EN);
  localparam int CW = $clog2(FL);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic last_bit, accept, gap_load, gap_en, gap_done;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  // last_bit means x_out currently carries the final bit of the frame.
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CW'(FL - 1));
  assign in_ready = !reset && ((state_q == ST_IDLE) || (last_bit && (GAP_CYCLES == 0)));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    x_out_d   = IDLE_LEVEL;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
    gap_load  = 1'b0;
    gap_en    = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_SHIFT: begin
        if (!last_bit) begin
          cnt_d     = cnt_q + CW'(1);
          x_valid_d = 1'b1;
          done_d    = (cnt_q == CW'(FL - 2));
          x_out_d   = head_bit(shift_q);
          shift_d   = advance(shift_q);
`ifdef BIT_SERIALIZER_PARITY_EN
          if (cnt_q == CW'(WIDTH - 1)) x_out_d = parity_q;
`endif
        end else if (GAP_CYCLES > 0) begin
          state_d  = ST_GAP;
          gap_load = 1'b1;
        end else if (!accept) begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        gap_en = 1'b1;
        if (gap_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A handshake, whether from IDLE or on the final bit, reloads the frame.
    if (accept) begin
      state_d   = ST_SHIFT;
      cnt_d     = '0;
      x_valid_d = 1'b1;
      x_out_d   = head_bit(in_data);
      shift_d   = advance(in_data);
      done_d    = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_d  = ^in_data;
`endif
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      x_out_q   <= IDLE_LEVEL;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  ser_gap_counter #(.W(GW)) u_gap (
    .clk        (clk),
    .reset      (reset),
    .load_i     (gap_load),
    .load_val_i (GW'(GAP_CYCLES)),
    .en_i       (gap_en),
    .done_o     (gap_done)
  );

  assign x_out      = x_out_q;
  assign x_valid    = x_valid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: dut0 uses defaults (MSB first, no gap); dut1 is LSB first with a 3-cycle gap.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] d0, d1;
  logic       v0, v1;
  logic       r0, x0, xv0, b0, fd0;
  logic       r1, x1, xv1, b1, fd1;

  int passes = 0;
  int total  = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(v0), .in_ready(r0),
    .x_out(x0), .x_valid(xv0), .busy(b0), .frame_done(fd0)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(3), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(r1),
    .x_out(x1), .x_valid(xv1), .busy(b1), .frame_done(fd1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected bit idx (0-based) of a frame; index 8 is the even-parity bit.
  function automatic logic exp_bit(input logic [7:0] w, input int idx, input bit msb);
    if (idx == 8) return ^w;
    return msb ? w[7 - idx] : w[idx];
  endfunction

  initial begin
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    tick(); tick();
    chk("rst_ready0", r0, 1'b0);
    chk("rst_ready1", r1, 1'b0);
    chk("rst_x0", x0, 1'b0);
    chk("rst_xv0", xv0, 1'b0);
    chk("rst_busy0", b0, 1'b0);
    chk("rst_done0", fd0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_x", x0, 1'b0);
      chk("idle_xv", xv0, 1'b0);
      chk("idle_busy", b0, 1'b0);
      chk("idle_ready", r0, 1'b1);
      chk("idle_done", fd0, 1'b0);
    end

    // 8'hA5 MSB first: 1,0,1,0,0,1,0,1; data changed after handshake must not matter.
    d0 = 8'hA5; v0 = 1'b1;
    tick();
    v0 = 1'b0; d0 = 8'h00;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) tick();
      chk("a5_bit", x0, exp_bit(8'hA5, i, 1'b1));
      chk("a5_xv", xv0, 1'b1);
      chk("a5_busy", b0, 1'b1);
      chk("a5_done", fd0, i == FL - 1);
      chk("a5_ready", r0, i == FL - 1);
    end
    tick();
    chk("a5_after_xv", xv0, 1'b0);
    chk("a5_after_busy", b0, 1'b0);
    chk("a5_after_done", fd0, 1'b0);

    // Back-to-back F0 then 0F with valid held high.
    d0 = 8'hF0; v0 = 1'b1;
    tick();
    d0 = 8'h0F;
    for (int i = 0; i < 2 * FL; i++) begin
      if (i > 0) tick();
      chk("b2b_bit", x0, exp_bit(i < FL ? 8'hF0 : 8'h0F, i % FL, 1'b1));
      chk("b2b_xv", xv0, 1'b1);
      chk("b2b_done", fd0, (i % FL) == FL - 1);
      if (i == FL) v0 = 1'b0;
    end
    tick();
    chk("b2b_after_xv", xv0, 1'b0);
    chk("b2b_after_busy", b0, 1'b0);

    // Reset after four bits of 8'hFF aborts the frame.
    d0 = 8'hFF; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    tick(); tick(); tick();
    chk("abort_bit4", x0, 1'b1);
    reset = 1'b1;
    tick();
    chk("abort_x", x0, 1'b0);
    chk("abort_xv", xv0, 1'b0);
    chk("abort_busy", b0, 1'b0);
    chk("abort_done", fd0, 1'b0);
    chk("abort_ready_in_reset", r0, 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", r0, 1'b1);
    d0 = 8'h3C; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) tick();
      chk("post_bit", x0, exp_bit(8'h3C, i, 1'b1));
      chk("post_done", fd0, i == FL - 1);
    end
    tick();
    chk("post_after_xv", xv0, 1'b0);

    // dut1: 8'h01 LSB first -> 1,0,0,0,0,0,0,0 then three gap cycles.
    d1 = 8'h01; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) tick();
      chk("gap_bit", x1, exp_bit(8'h01, i, 1'b0));
      chk("gap_xv", xv1, 1'b1);
      chk("gap_done", fd1, i == FL - 1);
      chk("gap_ready", r1, 1'b0);
    end
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("gap_cyc_x", x1, 1'b0);
      chk("gap_cyc_xv", xv1, 1'b0);
      chk("gap_cyc_busy", b1, 1'b1);
      chk("gap_cyc_ready", r1, 1'b0);
      chk("gap_cyc_done", fd1, 1'b0);
    end
    tick();
    chk("gap_end_busy", b1, 1'b0);
    chk("gap_end_ready", r1, 1'b1);
    chk("gap_end_xv", xv1, 1'b0);

`ifdef BIT_SERIALIZER_PARITY_EN
    // 8'h07 has three ones, so the parity bit is 1.
    d0 = 8'h07; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) tick();
      chk("par_bit", x0, exp_bit(8'h07, i, 1'b1));
      chk("par_xv", xv0, 1'b1);
      chk("par_done", fd0, i == FL - 1);
    end
    chk("par_last", x0, 1'b1);
    tick();
    chk("par_after_xv", xv0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
